// File: rtl/serial_subtractor_nand_pkg.sv
// Shared definitions for the NAND-based serial arithmetic blocks:
// FSM state encodings, the default operand width and a counter-width helper.
package serial_subtractor_nand_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bits needed to count 0..width-1; never less than one bit.
  function automatic int cnt_bits(input int width);
    if (width <= 2) begin
      return 1;
    end else begin
      return $clog2(width);
    end
  endfunction

endpackage

// File: rtl/full_subtractor_nand.sv
// One-bit full subtractor (x - y - bin) built only from 2-input NAND gates:
// two NAND half-subtractors, with the two borrows merged by a NAND acting as
// an OR of the inverted borrow terms.
module full_subtractor_nand (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic n1_s, n2_s, n3_s, d1_s;
  logic nx_s, b1_n_s;
  logic m1_s, m2_s, m3_s;
  logic nd1_s, b2_n_s;

  // First half-subtractor: d1 = x ^ y, b1_n = ~(~x & y)
  nand u_h1_x1 (n1_s, x, y);
  nand u_h1_x2 (n2_s, x, n1_s);
  nand u_h1_x3 (n3_s, y, n1_s);
  nand u_h1_x4 (d1_s, n2_s, n3_s);
  nand u_h1_inv (nx_s, x, x);
  nand u_h1_brw (b1_n_s, nx_s, y);

  // Second half-subtractor: d = d1 ^ bin, b2_n = ~(~d1 & bin)
  nand u_h2_x1 (m1_s, d1_s, bin);
  nand u_h2_x2 (m2_s, d1_s, m1_s);
  nand u_h2_x3 (m3_s, bin, m1_s);
  nand u_h2_x4 (d, m2_s, m3_s);
  nand u_h2_inv (nd1_s, d1_s, d1_s);
  nand u_h2_brw (b2_n_s, nd1_s, bin);

  // bout = b1 | b2, taken from the already-inverted borrow terms
  nand u_bor (bout, b1_n_s, b2_n_s);

endmodule

// File: rtl/serial_subtractor_nand.sv
// Bit-serial unsigned subtractor diff = a - b, LSB first, one bit per clock.
// Operands are captured on an accepted start, shifted through a NAND full
// subtractor, and the result/borrow are published only on completion.
module serial_subtractor_nand
  import serial_subtractor_nand_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = cnt_bits(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_r;
  state_t           state_nx_s;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;
  logic             bout_r;
  logic             busy_r;
  logic             done_r;
  logic [CW-1:0]    cnt_r;
  logic             d_s;
  logic             bo_s;

  full_subtractor_nand u_fs (
    .x    (a_sr_r[0]),
    .y    (b_sr_r[0]),
    .bin  (borrow_r),
    .d    (d_s),
    .bout (bo_s)
  );

  // Next-state logic: start is honoured only in IDLE, DONE always returns to IDLE
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = SHIFT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == CNT_LAST) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = SHIFT;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register plus registered busy/done decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == SHIFT);
      done_r  <= (state_nx_s == DONE);
    end
  end

  // Operand capture, serial shift and final result publication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_r   <= '0;
      b_sr_r   <= '0;
      res_r    <= '0;
      diff_r   <= '0;
      borrow_r <= 1'b0;
      bout_r   <= 1'b0;
      cnt_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sr_r   <= a;
            b_sr_r   <= b;
            borrow_r <= 1'b0;
            cnt_r    <= '0;
          end
        end
        SHIFT: begin
          a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
          res_r    <= {d_s, res_r[WIDTH-1:1]};
          borrow_r <= bo_s;
          cnt_r    <= cnt_r + CW'(1);
          // Last bit: publish the full result so diff never shows partials
          if (cnt_r == CNT_LAST) begin
            diff_r <= {d_s, res_r[WIDTH-1:1]};
            bout_r <= bo_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign diff = diff_r;
  assign bout = bout_r;

endmodule

// File: tb/tb_serial_subtractor_nand.sv
// Self-checking bench: 8-bit vector table, ignored-start and abort sequences,
// and a 16-bit back-to-back random sweep against an arithmetic reference.
module tb_serial_subtractor_nand;

  logic        clk;
  logic        rst_n;
  logic        start8, busy8, done8, bout8;
  logic [7:0]  a8, b8, diff8;
  logic        start16, busy16, done16, bout16;
  logic [15:0] a16, b16, diff16;

  int cyc = 0;
  int checks = 0;
  int passes = 0;
  int busy_cnt8 = 0;
  int busy_cnt16 = 0;
  int last_done16 = -1;

  typedef struct {
    logic [15:0] d;
    logic        bo;
    int          t0;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  exp_t q8[$];
  exp_t q16[$];
  vec_t vecs[8];

  serial_subtractor_nand #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor_nand #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .diff(diff16), .bout(bout16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // 8-bit result monitor
  always @(negedge clk) begin : mon8
    exp_t e;
    if (!rst_n) begin
      busy_cnt8 = 0;
    end else begin
      if (busy8) busy_cnt8++;
      if (done8) begin
        if (q8.size() == 0) begin
          checks++;
          $display("FAIL done8_unexpected: done pulse with no pending op at cycle %0d", cyc);
        end else begin
          e = q8.pop_front();
          chk("diff8", 32'(diff8), 32'(e.d));
          chk("bout8", 32'(bout8), 32'(e.bo));
          chk("latency8", cyc - e.t0, 9);
          chk("busy8_len", busy_cnt8, 8);
        end
        busy_cnt8 = 0;
      end
    end
  end

  // 16-bit result monitor, also checking back-to-back spacing
  always @(negedge clk) begin : mon16
    exp_t e;
    if (!rst_n) begin
      busy_cnt16 = 0;
    end else begin
      if (busy16) busy_cnt16++;
      if (done16) begin
        if (q16.size() == 0) begin
          checks++;
          $display("FAIL done16_unexpected: done pulse with no pending op at cycle %0d", cyc);
        end else begin
          e = q16.pop_front();
          chk("diff16", 32'(diff16), 32'(e.d));
          chk("bout16", 32'(bout16), 32'(e.bo));
          chk("latency16", cyc - e.t0, 17);
          chk("busy16_len", busy_cnt16, 16);
          if (last_done16 >= 0) chk("spacing16", cyc - last_done16, 18);
          last_done16 = cyc;
        end
        busy_cnt16 = 0;
      end
    end
  end

  task automatic drain8(input int n);
    for (int i = 0; i < n && q8.size() != 0; i++) @(posedge clk);
    if (q8.size() != 0) begin
      checks++;
      $display("FAIL timeout8: %0d ops still pending", q8.size());
      q8.delete();
    end
  endtask

  task automatic drain16(input int n);
    for (int i = 0; i < n && q16.size() != 0; i++) @(posedge clk);
    if (q16.size() != 0) begin
      checks++;
      $display("FAIL timeout16: %0d ops still pending", q16.size());
      q16.delete();
    end
  endtask

  task automatic push8(input logic [7:0] d, input logic bo);
    exp_t e;
    e.d  = {8'd0, d};
    e.bo = bo;
    e.t0 = cyc;
    q8.push_back(e);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] d, input logic bo);
    @(posedge clk); #1;
    a8 = a; b8 = b; start8 = 1'b1;
    push8(d, bo);
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    drain8(30);
  endtask

  initial begin
    logic [16:0] r;
    exp_t e;

    vecs[0] = '{8'd100, 8'd37,  8'd63,  1'b0};
    vecs[1] = '{8'd5,   8'd9,   8'd252, 1'b1};
    vecs[2] = '{8'd0,   8'd1,   8'd255, 1'b1};
    vecs[3] = '{8'd255, 8'd255, 8'd0,   1'b0};
    vecs[4] = '{8'd0,   8'd0,   8'd0,   1'b0};
    vecs[5] = '{8'd128, 8'd1,   8'd127, 1'b0};
    vecs[6] = '{8'd37,  8'd100, 8'd193, 1'b1};
    vecs[7] = '{8'd1,   8'd255, 8'd2,   1'b1};

    // Reset with random inputs and start asserted
    rst_n = 1'b0;
    start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
    start16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom);
    #23;
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);
    chk("rst_diff", 32'(diff8), 0);
    chk("rst_bout", 32'(bout8), 0);
    chk("rst_diff16", 32'(diff16), 0);
    start8 = 1'b0; start16 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy8), 0);
    chk("idle_done", 32'(done8), 0);

    // Vector table
    for (int i = 0; i < 8; i++) run8(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo);

    // Start re-pulsed during SHIFT is ignored
    @(posedge clk); #1;
    a8 = 8'd100; b8 = 8'd37; start8 = 1'b1;
    push8(8'd63, 1'b0);
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a8 = 8'd1; b8 = 8'd2; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    drain8(30);
    repeat (12) @(posedge clk);

    // Leave a nonzero result with borrow, then abort an operation by reset
    run8(8'd5, 8'd9, 8'd252, 1'b1);
    @(posedge clk); #1;
    a8 = 8'd200; b8 = 8'd50; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_diff", 32'(diff8), 0);
    chk("abort_bout", 32'(bout8), 0);
    chk("abort_busy", 32'(busy8), 0);
    chk("abort_done", 32'(done8), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    run8(8'd200, 8'd50, 8'd150, 1'b0);

    // 16-bit random sweep with start held high (back-to-back)
    @(posedge clk); #1;
    for (int n = 0; n < 1000; n++) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      if (n == 0) begin a16 = 16'd0; b16 = 16'd1; end
      if (n == 1) begin a16 = 16'hFFFF; b16 = 16'hFFFF; end
      start16 = 1'b1;
      r = {1'b0, a16} - {1'b0, b16};
      e.d  = r[15:0];
      e.bo = r[16];
      e.t0 = cyc;
      q16.push_back(e);
      repeat (18) @(posedge clk);
      #1;
    end
    start16 = 1'b0;
    drain16(40);
    repeat (20) @(posedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_nand.md
Name: serial_subtractor_nand

Overview:
Bit-serial WIDTH-bit subtractor computing diff = a - b, LSB first, one bit per clock. It is the subtract-direction counterpart of the team's NAND-only adders. The per-bit datapath is a full subtractor built only from 2-input NAND primitives; control is a small FSM with a start/done handshake. It sits beside the serial adder in the arithmetic test chain and feeds comparison and decrement logic.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only in IDLE
a  input  WIDTH  minuend; captured on the accepted start edge
b  input  WIDTH  subtrahend; captured on the accepted start edge
busy  output  1  high while the subtraction is in progress (SHIFT state)
done  output  1  single-cycle pulse when diff/bout are valid
diff  output  WIDTH  result (a - b) mod 2^WIDTH
bout  output  1  final borrow; 1 when a < b as unsigned values

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on rst_n; the design uses no synchronous reset.
- Reset values (rst_n low): state=IDLE, busy=0, done=0, diff=0, bout=0, internal shift registers=0, borrow flop=0, bit counter=0.
- FSM states:
  - IDLE: on start=1, load a_sr<=a, b_sr<=b, borrow<=0, cnt<=0, and go to SHIFT.
  - SHIFT: on each edge, the NAND full subtractor takes d = a_sr[0] ^ b_sr[0] ^ borrow and bo = (~a_sr[0] & b_sr[0]) | (~(a_sr[0]^b_sr[0]) & borrow).
    - d is shifted into the result register MSB-first, so after WIDTH shifts the LSB sits at bit 0.
    - a_sr and b_sr shift right by 1; borrow<=bo; cnt++.
    - When cnt==WIDTH-1, the final shift occurs and the FSM goes to DONE.
  - DONE: done=1 for exactly one cycle; then return to IDLE unconditionally.
- Timing: with start sampled at edge E0, SHIFT occupies the cycles after E0 through edge E_WIDTH.
  - busy=1 exactly WIDTH cycles.
  - done=1 in the cycle following E_WIDTH, i.e. WIDTH+1 cycles after the start edge.
- diff and bout are updated only at the transition into DONE. They hold their value until the next completion or reset; they never show partial results.
- start while busy=1, or in DONE, is ignored and has no effect on the running operation. start held high continuously gives back-to-back operations with one IDLE cycle between them.
- a and b may change freely after the start edge; only the captured values are used.
- Arithmetic is unsigned modulo 2^WIDTH; bout is the borrow out of the MSB.
  - a == b gives diff=0, bout=0.
  - 0 - 1 gives all-ones, bout=1.
- Reset asserted mid-operation aborts immediately. All state returns to reset values, no done pulse is produced, and the previous diff is cleared to 0.
- The combinational per-bit logic uses only nand primitives. Flops and the FSM are behavioural.

Decomposition:
- A shared header/package holds the FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH constant. The serial adder reuses them.
- One sub-module: full_subtractor_nand (inputs x, y, bin; outputs d, bout). It is built as two NAND half-subtractors plus a NAND-based OR of the borrows, instantiated once per serial step.

Test Plan:
- Reset: rst_n=0 with random inputs -> busy=0, done=0, diff=0, bout=0; after release, remain idle with start=0.
- a=100, b=37, start pulse -> busy=1 for 8 cycles, done pulse at cycle 9, diff=63, bout=0.
- a=5, b=9 -> diff=252 (0xFC), bout=1; a=0, b=1 -> diff=255, bout=1; a=255, b=255 -> diff=0, bout=0.
- start re-pulsed at cycle 3 of an operation with different a/b -> ignored; original result delivered on schedule, and exactly one done pulse.
- rst_n driven low at cycle 4 of a=200, b=50 -> outputs cleared at once, no done pulse; a fresh start after release gives diff=150, bout=0.
- WIDTH=16, random sweep of 1000 operand pairs vs. a reference model -> diff/bout always match, latency always 17 cycles; start held high gives back-to-back ops 18 cycles apart.
